// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;

   localparam int unsigned InstAddrWidth     = 32;
   localparam int unsigned InstWidth         = 32;
   localparam int unsigned IndexWidthDefault = 7;

   typedef logic [InstAddrWidth-1:0] inst_addr_t;
   typedef logic [InstWidth-1:0]     inst_t;

   localparam inst_t ZeroWord = '0;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StMiss = 2'd1
   } icache_state_e;

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: asynchronous read, synchronous write, valid bits cleared by reset.
module icache_array
   import icache_pkg::*;
#(
   parameter int unsigned INDEX_WIDTH = IndexWidthDefault,
   parameter int unsigned TAG_WIDTH   = 23
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [INDEX_WIDTH-1:0] rd_idx_i,
   output logic                   rd_valid_o,
   output logic [TAG_WIDTH-1:0]   rd_tag_o,
   output inst_t                  rd_data_o,
   input  logic                   we_i,
   input  logic [INDEX_WIDTH-1:0] wr_idx_i,
   input  logic [TAG_WIDTH-1:0]   wr_tag_i,
   input  inst_t                  wr_data_i
);

   localparam int unsigned Lines = 1 << INDEX_WIDTH;

   logic [Lines-1:0]     valid_q;
   logic [TAG_WIDTH-1:0] tag_q  [Lines];
   inst_t                data_q [Lines];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
      end else if (we_i) begin
         valid_q[wr_idx_i] <= 1'b1;
      end
   end

   // Tag and data carry no reset; the valid bit gates their use.
   always_ff @(posedge clk) begin
      if (we_i) begin
         tag_q[wr_idx_i]  <= wr_tag_i;
         data_q[wr_idx_i] <= wr_data_i;
      end
   end

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];
   assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped one-word-line instruction cache with single-word refill FSM.
// Define ICACHE_PERF_EN to add hit/miss performance counter outputs.
module icache
   import icache_pkg::*;
#(
   parameter int unsigned INDEX_WIDTH = IndexWidthDefault,
   parameter int unsigned ADDR_WIDTH  = InstAddrWidth
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush_in,
   input  logic                  inst_enable_in,
   input  logic [ADDR_WIDTH-1:0] inst_addr_in,
   output logic                  inst_enable_out,
   output inst_t                 inst_value_out,
   output logic                  mem_req_out,
   output logic [ADDR_WIDTH-1:0] mem_addr_out,
   input  logic                  mem_valid_in,
   input  inst_t                 mem_data_in
`ifdef ICACHE_PERF_EN
   ,
   output logic [31:0]           hit_cnt_out,
   output logic [31:0]           miss_cnt_out
`endif
);

   localparam int unsigned TagWidth = ADDR_WIDTH - INDEX_WIDTH - 2;

   icache_state_e         state_q, state_d;
   logic                  squash_q, squash_d;
   logic [ADDR_WIDTH-1:0] miss_addr_q, miss_addr_d;

   logic [INDEX_WIDTH-1:0] rd_idx;
   logic                   rd_valid;
   logic [TagWidth-1:0]    rd_tag;
   inst_t                  rd_data;
   logic                   fill_we;
   logic                   hit;

   icache_array #(
      .INDEX_WIDTH (INDEX_WIDTH),
      .TAG_WIDTH   (TagWidth)
   ) u_array (
      .clk        (clk),
      .rst        (rst),
      .rd_idx_i   (rd_idx),
      .rd_valid_o (rd_valid),
      .rd_tag_o   (rd_tag),
      .rd_data_o  (rd_data),
      .we_i       (fill_we),
      .wr_idx_i   (miss_addr_q[INDEX_WIDTH+1:2]),
      .wr_tag_i   (miss_addr_q[ADDR_WIDTH-1:INDEX_WIDTH+2]),
      .wr_data_i  (mem_data_in)
   );

   assign rd_idx = inst_addr_in[INDEX_WIDTH+1:2];

   always_comb begin
      state_d         = state_q;
      squash_d        = squash_q;
      miss_addr_d     = miss_addr_q;
      inst_enable_out = 1'b0;
      inst_value_out  = ZeroWord;
      mem_req_out     = 1'b0;
      mem_addr_out    = '0;
      fill_we         = 1'b0;
      hit             = 1'b0;
      case (state_q)
         StIdle: begin
            hit = inst_enable_in && rd_valid && !flush_in &&
                  (rd_tag == inst_addr_in[ADDR_WIDTH-1:INDEX_WIDTH+2]);
            if (hit) begin
               inst_enable_out = 1'b1;
               inst_value_out  = rd_data;
            end else if (inst_enable_in && !flush_in) begin
               miss_addr_d = inst_addr_in;
               state_d     = StMiss;
            end
         end
         StMiss: begin
            mem_req_out  = 1'b1;
            mem_addr_out = miss_addr_q;
            if (flush_in) begin
               squash_d = 1'b1;
            end
            if (mem_valid_in) begin
               fill_we = 1'b1;
               // Forward the refill only if IF is still asking for the same word.
               if (!squash_q && !flush_in && inst_enable_in && (inst_addr_in == miss_addr_q)) begin
                  inst_enable_out = 1'b1;
                  inst_value_out  = mem_data_in;
               end
               state_d  = StIdle;
               squash_d = 1'b0;
            end
         end
         default: begin
            state_d  = StIdle;
            squash_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         squash_q    <= 1'b0;
         miss_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         squash_q    <= squash_d;
         miss_addr_q <= miss_addr_d;
      end
   end

`ifdef ICACHE_PERF_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;
   logic        miss_start;

   assign miss_start = (state_q == StIdle) && (state_d == StMiss);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (hit) begin
            hit_cnt_q <= hit_cnt_q + 32'd1;
         end
         if (miss_start) begin
            miss_cnt_q <= miss_cnt_q + 32'd1;
         end
      end
   end

   assign hit_cnt_out  = hit_cnt_q;
   assign miss_cnt_out = miss_cnt_q;
`endif

endmodule
